fw_pipe_bank: RTL

- Parametrised result-tracking and forwarding pipeline for an N-issue SPU core.
- Generalises the fixed two-pipe, stage-2..7 scheme. Each pipe carries in-flight destination tags through DEPTH stages.
- Each pipe captures its functional-unit result at a per-instruction latency, forwards the youngest matching result to every source operand, raises stall requests for results not yet produced, and drives register-file writeback at the last stage.
- Sits between reg_file read ports and the execution pipes.

---
 rtl/fw_pipe_bank_pkg.sv | 14 +
 rtl/fw_pipe_bank_if.sv | 38 +++
 rtl/fw_pipe_bank_src_select.sv | 30 +++
 rtl/fw_pipe_bank.sv | 125 ++++++++++++
 4 files changed

// File: rtl/fw_pipe_bank_pkg.sv
// Shared constants for the forwarding pipeline bank: default geometry,
// sticky error bit positions and the latency legality check.
package fw_pipe_bank_pkg;

  localparam int FWD_DEPTH   = 7;
  localparam int FWD_SRC     = 3;
  localparam int ERR_COLLIDE = 0;
  localparam int ERR_LAT     = 1;

  function automatic logic lat_legal(input int lat, input int depth);
    return (lat >= 1) && (lat <= depth);
  endfunction

endpackage

// File: rtl/fw_pipe_bank_if.sv
// Issue, result, operand and writeback bundle between the SPU issue logic
// and the forwarding bank.
interface fw_pipe_bank_if import fw_pipe_bank_pkg::*; #(
  parameter int NUM_PIPES = 2,
  parameter int NUM_SRC   = FWD_SRC,
  parameter int DATA_WD   = 128,
  parameter int ADDR_WD   = 7,
  parameter int LAT_WD    = $clog2(FWD_DEPTH + 1)
);

  logic [NUM_PIPES-1:0]                 iss_valid;
  logic [NUM_PIPES-1:0]                 iss_wr_en;
  logic [NUM_PIPES*ADDR_WD-1:0]         iss_rt_addr;
  logic [NUM_PIPES*LAT_WD-1:0]          iss_lat;
  logic [NUM_PIPES*DATA_WD-1:0]         res_data;
  logic [NUM_PIPES*NUM_SRC*ADDR_WD-1:0] src_addr;
  logic [NUM_PIPES*NUM_SRC*DATA_WD-1:0] rf_rd_data;
  logic                                 flush;
  logic [NUM_PIPES*NUM_SRC*DATA_WD-1:0] fwd_data;
  logic [NUM_PIPES-1:0]                 stall_req;
  logic [NUM_PIPES-1:0]                 wb_en;
  logic [NUM_PIPES*ADDR_WD-1:0]         wb_addr;
  logic [NUM_PIPES*DATA_WD-1:0]         wb_data;
  logic [1:0]                           err;

  modport master (
    output iss_valid, iss_wr_en, iss_rt_addr, iss_lat, res_data,
           src_addr, rf_rd_data, flush,
    input  fwd_data, stall_req, wb_en, wb_addr, wb_data, err
  );

  modport slave (
    input  iss_valid, iss_wr_en, iss_rt_addr, iss_lat, res_data,
           src_addr, rf_rd_data, flush,
    output fwd_data, stall_req, wb_en, wb_addr, wb_data, err
  );

endinterface

// File: rtl/fw_pipe_bank_src_select.sv
// Priority mux for one source operand: candidate 0 is the youngest entry;
// the youngest match supplies data, or a stall if its result is not yet known.
module fw_src_select #(
  parameter int NCAND   = 14,
  parameter int DATA_WD = 128,
  parameter int ADDR_WD = 7
) (
  input  logic [NCAND-1:0]         cand_en_i,
  input  logic [NCAND*ADDR_WD-1:0] cand_addr_i,
  input  logic [NCAND-1:0]         cand_avail_i,
  input  logic [NCAND*DATA_WD-1:0] cand_data_i,
  input  logic [ADDR_WD-1:0]       src_addr_i,
  input  logic [DATA_WD-1:0]       rf_data_i,
  output logic [DATA_WD-1:0]       data_o,
  output logic                     stall_o
);

  always_comb begin
    data_o  = rf_data_i;
    stall_o = 1'b0;
    // Walk oldest to youngest so the last hit (lowest index) wins.
    for (int i = NCAND - 1; i >= 0; i--) begin
      if (cand_en_i[i] && (cand_addr_i[i*ADDR_WD +: ADDR_WD] == src_addr_i)) begin
        data_o  = cand_data_i[i*DATA_WD +: DATA_WD];
        stall_o = !cand_avail_i[i];
      end
    end
  end

endmodule

// File: rtl/fw_pipe_bank.sv
// N-pipe result tracker: shifts destination tags through DEPTH stages, captures
// unit results at their completion stage, forwards operands and drives writeback.
module fw_pipe_bank import fw_pipe_bank_pkg::*; #(
  parameter int NUM_PIPES    = 2,
  parameter int DEPTH        = FWD_DEPTH,
  parameter int NUM_SRC      = FWD_SRC,
  parameter int DATA_WD      = 128,
  parameter int ADDR_WD      = 7,
  parameter int LAT_WD       = $clog2(DEPTH + 1),
  parameter int FLUSH_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  fw_pipe_bank_if.slave bus
);

  localparam int NCAND = NUM_PIPES * DEPTH;

  typedef struct packed {
    logic               valid;
    logic               wr_en;
    logic [ADDR_WD-1:0] addr;
    logic [LAT_WD-1:0]  lat;
    logic               ready;
    logic [DATA_WD-1:0] data;
  } entry_t;

  entry_t ent_q [NUM_PIPES][1:DEPTH];
  entry_t ent_d [NUM_PIPES][1:DEPTH];
  logic [1:0] err_q, err_d;

  logic [NUM_PIPES-1:0][DEPTH:1]     live_v, done_v;
  logic [NUM_PIPES-1:0][LAT_WD-1:0]  lat_fix;
  logic [NUM_PIPES-1:0]              lat_ok, collide_p;
  logic [NCAND-1:0]                  cand_en, cand_avail;
  logic [NCAND*ADDR_WD-1:0]          cand_addr;
  logic [NCAND*DATA_WD-1:0]          cand_data;
  logic [NUM_PIPES*NUM_SRC-1:0]      stall_bits;

  genvar gi, gs;
  generate
    for (gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
      assign lat_ok[gi]  = lat_legal(int'(bus.iss_lat[gi*LAT_WD +: LAT_WD]), DEPTH);
      assign lat_fix[gi] = lat_ok[gi] ? bus.iss_lat[gi*LAT_WD +: LAT_WD] : LAT_WD'(DEPTH);
      assign collide_p[gi] = |(done_v[gi] & (done_v[gi] - DEPTH'(1)));

      for (gs = 1; gs <= DEPTH; gs++) begin : g_stage
        // Youngest stage first; within a stage the higher pipe is later in program order.
        localparam int CI = (gs - 1) * NUM_PIPES + (NUM_PIPES - 1 - gi);
        assign live_v[gi][gs] = ent_q[gi][gs].valid && !(bus.flush && (gs <= FLUSH_STAGES));
        assign done_v[gi][gs] = live_v[gi][gs] && (ent_q[gi][gs].lat == LAT_WD'(gs));
        assign cand_en[CI]    = live_v[gi][gs] && ent_q[gi][gs].wr_en;
        assign cand_avail[CI] = ent_q[gi][gs].ready || done_v[gi][gs];
        assign cand_addr[CI*ADDR_WD +: ADDR_WD] = ent_q[gi][gs].addr;
        assign cand_data[CI*DATA_WD +: DATA_WD] = ent_q[gi][gs].ready ? ent_q[gi][gs].data
                                                  : bus.res_data[gi*DATA_WD +: DATA_WD];
      end

      assign bus.wb_en[gi] = live_v[gi][DEPTH] && ent_q[gi][DEPTH].wr_en;
      assign bus.wb_addr[gi*ADDR_WD +: ADDR_WD] = ent_q[gi][DEPTH].addr;
      assign bus.wb_data[gi*DATA_WD +: DATA_WD] = ent_q[gi][DEPTH].ready ? ent_q[gi][DEPTH].data
                                                  : bus.res_data[gi*DATA_WD +: DATA_WD];
      assign bus.stall_req[gi] = |stall_bits[gi*NUM_SRC +: NUM_SRC];

      for (gs = 0; gs < NUM_SRC; gs++) begin : g_src
        localparam int SI = gi * NUM_SRC + gs;
        fw_src_select #(
          .NCAND   (NCAND),
          .DATA_WD (DATA_WD),
          .ADDR_WD (ADDR_WD)
        ) u_sel (
          .cand_en_i    (cand_en),
          .cand_addr_i  (cand_addr),
          .cand_avail_i (cand_avail),
          .cand_data_i  (cand_data),
          .src_addr_i   (bus.src_addr[SI*ADDR_WD +: ADDR_WD]),
          .rf_data_i    (bus.rf_rd_data[SI*DATA_WD +: DATA_WD]),
          .data_o       (bus.fwd_data[SI*DATA_WD +: DATA_WD]),
          .stall_o      (stall_bits[SI])
        );
      end
    end
  endgenerate

  // Every completing entry latches its pipe's result, so a colliding younger
  // entry ends up ready with the same data as the older one.
  always_comb begin
    for (int p = 0; p < NUM_PIPES; p++) begin
      ent_d[p][1]       = '0;
      ent_d[p][1].valid = bus.iss_valid[p] && !bus.flush;
      ent_d[p][1].wr_en = bus.iss_wr_en[p];
      ent_d[p][1].addr  = bus.iss_rt_addr[p*ADDR_WD +: ADDR_WD];
      ent_d[p][1].lat   = lat_fix[p];
      for (int s = 2; s <= DEPTH; s++) begin
        ent_d[p][s]       = ent_q[p][s-1];
        ent_d[p][s].valid = live_v[p][s-1];
        if (done_v[p][s-1]) begin
          ent_d[p][s].ready = 1'b1;
          ent_d[p][s].data  = bus.res_data[p*DATA_WD +: DATA_WD];
        end
      end
    end
  end

  always_comb begin
    err_d = err_q;
    err_d[ERR_COLLIDE] = err_q[ERR_COLLIDE] | (|collide_p);
    err_d[ERR_LAT]     = err_q[ERR_LAT] | (|(bus.iss_valid & ~lat_ok));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PIPES; p++)
        for (int s = 1; s <= DEPTH; s++)
          ent_q[p][s] <= '0;
      err_q <= '0;
    end else begin
      ent_q <= ent_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;

endmodule
